// File: rtl/tbox_nk.sv
// tbox_nk: N x N tic-tac-toe board engine with K-in-a-row win detection.
// Stores the grid, enforces turn order, rejects bad requests, and finds a win
// by scanning the four lines through the last placed cell, one cell per cycle.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   set, row, col    move request and target cell
//   valid, symbol    per-cell occupied flag and symbol (1=X, 0=O), index row*N+col
//   game_state       00 ongoing, 01 X wins, 10 O wins, 11 draw
//   turn             side to move next (1=X)
//   busy             win scan in progress
//   illegal          one-cycle pulse after a rejected request
//   move_count       number of occupied cells
module tbox_nk #(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned IW = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int unsigned CW = $clog2(N * N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [IW-1:0]    row,
  input  logic [IW-1:0]    col,
  output logic [N*N-1:0]   valid,
  output logic [N*N-1:0]   symbol,
  output logic [1:0]       game_state,
  output logic             turn,
  output logic             busy,
  output logic             illegal,
  output logic [CW-1:0]    move_count
);

  localparam int unsigned NC  = N * N;
  localparam int unsigned XW  = $clog2(NC);
  localparam int unsigned SW  = IW + 2;
  localparam int unsigned IW1 = IW + 1;
  localparam int unsigned RW  = $clog2(K + 1);

  localparam logic signed [SW-1:0] N_S     = SW'(N);
  localparam logic signed [SW-1:0] OFF_MAX = SW'(K - 1);
  localparam logic signed [SW-1:0] OFF_MIN = -OFF_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [NC-1:0]        valid_n, symbol_n;
  logic [1:0]           game_state_n;
  logic                 turn_n, busy_n, illegal_n;
  logic [CW-1:0]        move_count_n;
  logic [IW-1:0]        r0, c0, r0_n, c0_n;
  logic                 m, m_n;
  logic [1:0]           d, d_n;
  logic signed [SW-1:0] off, off_n;
  logic [RW-1:0]        run, run_n;

  // Request decode: out-of-range coordinates never index the board.
  logic          in_range;
  logic [XW-1:0] req_idx;
  logic          accept;

  always_comb begin
    in_range = ({1'b0, row} < IW1'(N)) && ({1'b0, col} < IW1'(N));
    req_idx  = in_range ? (XW'(row) * XW'(N) + XW'(col)) : '0;
    accept   = (state == IDLE) && set && in_range && !valid[req_idx];
  end

  // Scan cell: origin plus signed offset along direction d; the two guard
  // bits keep off-board coordinates negative or >= N instead of wrapping.
  logic signed [SW-1:0] r0_s, c0_s, er, ec;
  logic                 in_board, hit;
  logic [XW-1:0]        scan_idx;
  logic [RW-1:0]        run_inc;

  always_comb begin
    r0_s = $signed({2'b00, r0});
    c0_s = $signed({2'b00, c0});
    er   = r0_s;
    ec   = c0_s;
    case (d)
      2'd0:    ec = c0_s + off;
      2'd1:    er = r0_s + off;
      2'd2:    begin er = r0_s + off; ec = c0_s + off; end
      default: begin er = r0_s + off; ec = c0_s - off; end
    endcase
    in_board = !er[SW-1] && (er < N_S) && !ec[SW-1] && (ec < N_S);
    scan_idx = in_board ? (XW'(er[IW-1:0]) * XW'(N) + XW'(ec[IW-1:0])) : '0;
    hit      = in_board && valid[scan_idx] && (symbol[scan_idx] == m);
    run_inc  = hit ? (run + RW'(1)) : '0;
  end

  // Next-state and output logic.
  always_comb begin
    state_n      = state;
    valid_n      = valid;
    symbol_n     = symbol;
    game_state_n = game_state;
    turn_n       = turn;
    move_count_n = move_count;
    r0_n         = r0;
    c0_n         = c0;
    m_n          = m;
    d_n          = d;
    off_n        = off;
    run_n        = run;
    illegal_n    = 1'b0;

    case (state)
      IDLE: begin
        if (set) begin
          if (accept) begin
            valid_n[req_idx]  = 1'b1;
            symbol_n[req_idx] = turn;
            move_count_n      = move_count + CW'(1);
            turn_n            = ~turn;
            r0_n              = row;
            c0_n              = col;
            m_n               = turn;
            d_n               = 2'd0;
            off_n             = OFF_MIN;
            run_n             = '0;
            state_n           = SCAN;
          end else begin
            illegal_n = 1'b1;
          end
        end
      end
      SCAN: begin
        illegal_n = set;
        if (run_inc == RW'(K)) begin
          run_n        = run_inc;
          game_state_n = m ? 2'b01 : 2'b10;
          state_n      = OVER;
        end else if (off == OFF_MAX) begin
          if (d == 2'd3) begin
            if (move_count == CW'(NC)) begin
              game_state_n = 2'b11;
              state_n      = OVER;
            end else begin
              state_n = IDLE;
            end
          end else begin
            d_n   = d + 2'd1;
            off_n = OFF_MIN;
            run_n = '0;
          end
        end else begin
          off_n = off + SW'(1);
          run_n = run_inc;
        end
      end
      OVER:    illegal_n = set;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SCAN);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      symbol     <= '0;
      game_state <= 2'b00;
      turn       <= 1'b1;
      move_count <= '0;
      busy       <= 1'b0;
      illegal    <= 1'b0;
      r0         <= '0;
      c0         <= '0;
      m          <= 1'b0;
      d          <= 2'd0;
      off        <= OFF_MIN;
      run        <= '0;
    end else begin
      state      <= state_n;
      valid      <= valid_n;
      symbol     <= symbol_n;
      game_state <= game_state_n;
      turn       <= turn_n;
      move_count <= move_count_n;
      busy       <= busy_n;
      illegal    <= illegal_n;
      r0         <= r0_n;
      c0         <= c0_n;
      m          <= m_n;
      d          <= d_n;
      off        <= off_n;
      run        <= run_n;
    end
  end

endmodule

// File: tb/tb_tbox_nk.sv
// Testbench for tbox_nk: a 3x3/K=3 instance and a 5x5/K=4 instance driven from
// a table of reset/move/bad-request records, plus hand-written sequences for
// reset during a scan and requests held during a scan.
module tb_tbox_nk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3x3, K=3 instance
  logic       a_reset, a_set;
  logic [1:0] a_row, a_col;
  logic [8:0] a_valid, a_symbol;
  logic [1:0] a_gs;
  logic       a_turn, a_busy, a_illegal;
  logic [3:0] a_mc;

  // 5x5, K=4 instance
  logic        b_reset, b_set;
  logic [2:0]  b_row, b_col;
  logic [24:0] b_valid, b_symbol;
  logic [1:0]  b_gs;
  logic        b_turn, b_busy, b_illegal;
  logic [4:0]  b_mc;

  tbox_nk #(.N(3), .K(3)) dut_a (
    .clk(clk), .reset(a_reset), .set(a_set), .row(a_row), .col(a_col),
    .valid(a_valid), .symbol(a_symbol), .game_state(a_gs), .turn(a_turn),
    .busy(a_busy), .illegal(a_illegal), .move_count(a_mc)
  );

  tbox_nk #(.N(5), .K(4)) dut_b (
    .clk(clk), .reset(b_reset), .set(b_set), .row(b_row), .col(b_col),
    .valid(b_valid), .symbol(b_symbol), .game_state(b_gs), .turn(b_turn),
    .busy(b_busy), .illegal(b_illegal), .move_count(b_mc)
  );

  int checks = 0;
  int errors = 0;

  typedef enum int {OP_RST, OP_MOVE, OP_BAD} op_t;

  typedef struct {
    op_t         op;
    int          dut;
    int          r;
    int          c;
    int          lat;   // edges from accept until busy falls
    logic [31:0] v;     // expected valid
    logic [31:0] s;     // expected symbol on occupied cells
    int          mc;
    logic        turn;
    int          gs;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int dut, input logic s, input int r, input int c);
    if (dut == 0) begin a_set = s; a_row = 2'(r); a_col = 2'(c); end
    else          begin b_set = s; b_row = 3'(r); b_col = 3'(c); end
  endtask

  task automatic set_reset(input int dut, input logic v);
    if (dut == 0) a_reset = v;
    else          b_reset = v;
  endtask

  function automatic logic [31:0] get_valid(input int dut);
    return (dut == 0) ? 32'(a_valid) : 32'(b_valid);
  endfunction
  function automatic logic [31:0] get_symbol(input int dut);
    return (dut == 0) ? 32'(a_symbol) : 32'(b_symbol);
  endfunction
  function automatic int get_mc(input int dut);
    return (dut == 0) ? int'(a_mc) : int'(b_mc);
  endfunction
  function automatic logic get_turn(input int dut);
    return (dut == 0) ? a_turn : b_turn;
  endfunction
  function automatic int get_gs(input int dut);
    return (dut == 0) ? int'(a_gs) : int'(b_gs);
  endfunction
  function automatic logic get_busy(input int dut);
    return (dut == 0) ? a_busy : b_busy;
  endfunction
  function automatic logic get_illegal(input int dut);
    return (dut == 0) ? a_illegal : b_illegal;
  endfunction

  task automatic check_board(input string tag, input int dut, input logic [31:0] v,
                             input logic [31:0] s, input int mc, input logic turn,
                             input int gs);
    check({tag, " valid"}, get_valid(dut), v);
    check({tag, " symbol"}, get_symbol(dut) & get_valid(dut), s);
    check({tag, " move_count"}, get_mc(dut), mc);
    check({tag, " turn"}, get_turn(dut), turn);
    check({tag, " game_state"}, get_gs(dut), gs);
  endtask

  task automatic add(input op_t op, input int dut, input int r, input int c, input int lat,
                     input logic [31:0] v, input logic [31:0] s, input int mc,
                     input logic turn, input int gs);
    vec_t t;
    t.op = op; t.dut = dut; t.r = r; t.c = c; t.lat = lat;
    t.v = v; t.s = s; t.mc = mc; t.turn = turn; t.gs = gs;
    vecs.push_back(t);
  endtask

  // Wait for busy to fall, counting edges; gives up after a fixed budget.
  task automatic wait_idle(input int dut, output int lat);
    lat = 0;
    while (get_busy(dut) && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    a_reset = 1'b0; a_set = 1'b0; a_row = '0; a_col = '0;
    b_reset = 1'b0; b_set = 1'b0; b_row = '0; b_col = '0;

    // Game 1 (3x3): X takes row 0
    add(OP_RST,  0, 0, 0, 0,  32'h000, 32'h000, 0, 1'b1, 0);
    add(OP_RST,  1, 0, 0, 0,  32'h000, 32'h000, 0, 1'b1, 0);
    add(OP_MOVE, 0, 0, 0, 20, 32'h001, 32'h001, 1, 1'b0, 0);
    add(OP_MOVE, 0, 1, 0, 20, 32'h009, 32'h001, 2, 1'b1, 0);
    add(OP_MOVE, 0, 0, 1, 20, 32'h00B, 32'h003, 3, 1'b0, 0);
    add(OP_MOVE, 0, 1, 1, 20, 32'h01B, 32'h003, 4, 1'b1, 0);
    add(OP_MOVE, 0, 0, 2, 3,  32'h01F, 32'h007, 5, 1'b0, 1);
    add(OP_BAD,  0, 1, 2, 0,  32'h01F, 32'h007, 5, 1'b0, 1);
    // Game 2 (3x3): draw, with bad requests early on
    add(OP_RST,  0, 0, 0, 0,  32'h000, 32'h000, 0, 1'b1, 0);
    add(OP_MOVE, 0, 0, 0, 20, 32'h001, 32'h001, 1, 1'b0, 0);
    add(OP_BAD,  0, 0, 0, 0,  32'h001, 32'h001, 1, 1'b0, 0);
    add(OP_BAD,  0, 3, 0, 0,  32'h001, 32'h001, 1, 1'b0, 0);
    add(OP_MOVE, 0, 0, 1, 20, 32'h003, 32'h001, 2, 1'b1, 0);
    add(OP_MOVE, 0, 0, 2, 20, 32'h007, 32'h005, 3, 1'b0, 0);
    add(OP_MOVE, 0, 1, 1, 20, 32'h017, 32'h005, 4, 1'b1, 0);
    add(OP_MOVE, 0, 1, 0, 20, 32'h01F, 32'h00D, 5, 1'b0, 0);
    add(OP_MOVE, 0, 1, 2, 20, 32'h03F, 32'h00D, 6, 1'b1, 0);
    add(OP_MOVE, 0, 2, 1, 20, 32'h0BF, 32'h08D, 7, 1'b0, 0);
    add(OP_MOVE, 0, 2, 0, 20, 32'h0FF, 32'h08D, 8, 1'b1, 0);
    add(OP_MOVE, 0, 2, 2, 20, 32'h1FF, 32'h18D, 9, 1'b0, 3);
    add(OP_BAD,  0, 0, 0, 0,  32'h1FF, 32'h18D, 9, 1'b0, 3);
    // Game 3 (3x3): corner (2,2) closes column 2; row 2 has only two X plus off-board
    add(OP_RST,  0, 0, 0, 0,  32'h000, 32'h000, 0, 1'b1, 0);
    add(OP_MOVE, 0, 0, 2, 20, 32'h004, 32'h004, 1, 1'b0, 0);
    add(OP_MOVE, 0, 0, 0, 20, 32'h005, 32'h004, 2, 1'b1, 0);
    add(OP_MOVE, 0, 2, 1, 20, 32'h085, 32'h084, 3, 1'b0, 0);
    add(OP_MOVE, 0, 1, 0, 20, 32'h08D, 32'h084, 4, 1'b1, 0);
    add(OP_MOVE, 0, 1, 2, 20, 32'h0AD, 32'h0A4, 5, 1'b0, 0);
    add(OP_MOVE, 0, 0, 1, 20, 32'h0AF, 32'h0A4, 6, 1'b1, 0);
    add(OP_MOVE, 0, 2, 2, 8,  32'h1AF, 32'h1A4, 7, 1'b0, 1);
    // Game 4 (5x5, K=4): O takes the anti-diagonal from (0,4) to (3,1)
    add(OP_MOVE, 1, 0, 0, 28, 32'h0000001, 32'h0000001, 1, 1'b0, 0);
    add(OP_MOVE, 1, 0, 4, 28, 32'h0000011, 32'h0000001, 2, 1'b1, 0);
    add(OP_MOVE, 1, 4, 4, 28, 32'h1000011, 32'h1000001, 3, 1'b0, 0);
    add(OP_MOVE, 1, 1, 3, 28, 32'h1000111, 32'h1000001, 4, 1'b1, 0);
    add(OP_MOVE, 1, 0, 1, 28, 32'h1000113, 32'h1000003, 5, 1'b0, 0);
    add(OP_MOVE, 1, 2, 2, 28, 32'h1001113, 32'h1000003, 6, 1'b1, 0);
    add(OP_MOVE, 1, 4, 0, 28, 32'h1101113, 32'h1100003, 7, 1'b0, 0);
    add(OP_BAD,  1, 5, 0, 0,  32'h1101113, 32'h1100003, 7, 1'b0, 0);
    add(OP_MOVE, 1, 3, 1, 25, 32'h1111113, 32'h1100003, 8, 1'b1, 2);

    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t  t;
      string tag;
      t   = vecs[i];
      tag = $sformatf("v%0d", i);
      case (t.op)
        OP_RST: begin
          set_reset(t.dut, 1'b1);
          tick();
          set_reset(t.dut, 1'b0);
          check({tag, " rst symbol"}, get_symbol(t.dut), 0);
          check({tag, " rst busy"}, get_busy(t.dut), 0);
          check({tag, " rst illegal"}, get_illegal(t.dut), 0);
          check_board(tag, t.dut, t.v, t.s, t.mc, t.turn, t.gs);
        end
        OP_MOVE: begin
          drive(t.dut, 1'b1, t.r, t.c);
          tick();
          drive(t.dut, 1'b0, 0, 0);
          check({tag, " busy at accept"}, get_busy(t.dut), 1);
          check({tag, " illegal at accept"}, get_illegal(t.dut), 0);
          wait_idle(t.dut, lat);
          check({tag, " scan latency"}, lat, t.lat);
          check_board(tag, t.dut, t.v, t.s, t.mc, t.turn, t.gs);
        end
        default: begin
          drive(t.dut, 1'b1, t.r, t.c);
          tick();
          drive(t.dut, 1'b0, 0, 0);
          check({tag, " illegal pulse"}, get_illegal(t.dut), 1);
          check({tag, " busy after bad"}, get_busy(t.dut), 0);
          check_board(tag, t.dut, t.v, t.s, t.mc, t.turn, t.gs);
          tick();
          check({tag, " illegal cleared"}, get_illegal(t.dut), 0);
        end
      endcase
    end

    // Reset in the second scan cycle aborts the scan; next move accepted at once
    set_reset(0, 1'b1);
    tick();
    set_reset(0, 1'b0);
    drive(0, 1'b1, 1, 1);
    tick();
    drive(0, 1'b0, 0, 0);
    check("midrst busy scan0", a_busy, 1);
    tick();
    check("midrst busy scan1", a_busy, 1);
    set_reset(0, 1'b1);
    tick();
    set_reset(0, 1'b0);
    check("midrst busy", a_busy, 0);
    check("midrst illegal", a_illegal, 0);
    check("midrst symbol", a_symbol, 0);
    check_board("midrst", 0, 32'h000, 32'h000, 0, 1'b1, 0);
    drive(0, 1'b1, 0, 0);
    tick();
    check("postrst busy", a_busy, 1);
    check_board("postrst", 0, 32'h001, 32'h001, 1, 1'b0, 0);

    // Request held during a scan: illegal on every edge, no write
    drive(0, 1'b1, 2, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("held set illegal %0d", k), a_illegal, 1);
      check($sformatf("held set valid %0d", k), a_valid, 9'h001);
    end
    drive(0, 1'b0, 0, 0);
    tick();
    check("held set released", a_illegal, 0);
    wait_idle(0, lat);
    check("held set scan finished", a_busy, 0);
    check_board("held set end", 0, 32'h001, 32'h001, 1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
